// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID stage: 2-entry skid buffer holding decoded instruction fields.
// Optional DECODE_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module if_id_decode #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [18:0]     imm_1,
    output logic [22:0]     imm_2,
    output logic [1:0]      imm_ctrl,
    output logic [3:0]      rd,
    output logic [3:0]      rn,
    output logic [3:0]      rm,
    output logic [1:0]      op_class
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int ENT_W = PC_W + 19 + 23 + 2 + 12 + 2;

    // Each entry is stored already decoded so the outputs are straight flop reads.
    function automatic logic [ENT_W-1:0] decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        logic [1:0] ctrl;
        case (instr[31:30])
            2'b00:   ctrl = instr[29] ? 2'b00 : 2'b11;
            2'b01:   ctrl = 2'b01;
            2'b10:   ctrl = 2'b10;
            default: ctrl = 2'b11;
        endcase
        return {pc, instr[18:0], instr[22:0], ctrl, instr[27:24], instr[23:20], instr[19:16], instr[31:30]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ENT_W-1:0] new_entry;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        new_entry = decode(in_instr, in_pc);
        in_xfer   = in_valid && in_ready_q;
        out_xfer  = out_valid_q && out_ready;
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        head_d  = new_entry;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_d = new_entry;
                    end else if (in_xfer) begin
                        state_d = ST_TWO;
                        tail_d  = new_entry;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {out_pc, imm_1, imm_2, imm_ctrl, rd, rn, rm, op_class} = head_q;

`ifdef DECODE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_valid && !in_ready_q && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && state_q != ST_EMPTY && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
